// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: FWFT FIFO read side plus the
// downstream valid/ready burst stream.
interface fifo_burst_reader_if #(
    parameter int WIDTH      = 32,
    parameter int DEEPTH_BIT = 6
);
    logic                  fifo_empty;
    logic [WIDTH-1:0]      fifo_dato;
    logic [DEEPTH_BIT-1:0] fifo_rlevel;
    logic                  fifo_rd_en;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [WIDTH-1:0]      m_data;
    logic                  m_last;
    logic [15:0]           burst_cnt;

    modport master (
        input  fifo_empty, fifo_dato, fifo_rlevel, flush, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, burst_cnt
    );

    modport slave (
        output fifo_empty, fifo_dato, fifo_rlevel, flush, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, burst_cnt
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Reads full (or flushed partial) bursts from an FWFT FIFO and presents them
// on a single-entry registered valid/ready stream with an end-of-burst marker.
module fifo_burst_reader #(
    parameter int WIDTH      = 32,
    parameter int DEEPTH_BIT = 6,
    parameter int BURST_LEN  = 8
) (
    input  logic                rclk,
    input  logic                rst,
    fifo_burst_reader_if.master bus
);
    localparam int          CW     = $clog2(BURST_LEN + 1);
    localparam logic [31:0] BL32   = 32'(BURST_LEN);
    localparam logic [CW-1:0] BL_CNT = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             last_q;
    logic [15:0]      bcnt_q;

    logic full_start;
    logic flush_start;
    logic pop;

    always_comb begin
        full_start  = 32'(bus.fifo_rlevel) >= BL32;
        // A zero level can never be drained, so it must not open a burst.
        flush_start = bus.flush && !bus.fifo_empty && (bus.fifo_rlevel != '0);
        pop         = (state_q == BURST) && (cnt_q != '0) && !bus.fifo_empty &&
                      (!valid_q || bus.m_ready);
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full_start) begin
                        state_q <= BURST;
                        cnt_q   <= BL_CNT;
                    end else if (flush_start) begin
                        state_q <= BURST;
                        cnt_q   <= CW'(bus.fifo_rlevel);
                    end
                end
                BURST: begin
                    if (pop) begin
                        cnt_q <= cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            state_q <= IDLE;
                            bcnt_q  <= bcnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Output register: a pop refills it, an accept without pop drains it.
            if (pop) begin
                data_q  <= bus.fifo_dato;
                valid_q <= 1'b1;
                last_q  <= (cnt_q == ONE);
            end else if (valid_q && bus.m_ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.m_valid    = valid_q;
    assign bus.m_data     = data_q;
    assign bus.m_last     = last_q;
    assign bus.burst_cnt  = bcnt_q;
endmodule
